// File: rtl/inst_decode_stage_if.sv
// Fetch-to-decode-to-execute bus: instruction handshake in, registered control bundle out.
interface inst_decode_stage_if #(
    parameter int DATA_W    = 32,
    parameter int ILL_CNT_W = 8
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          inst;
    logic                 flush;
    logic                 out_valid;
    logic                 out_ready;
    logic [3:0]           alu_op;
    logic                 write_reg;
    logic                 mem_write;
    logic                 mem_read;
    logic [1:0]           w_r_s;
    logic [1:0]           wr_data_s;
    logic                 rt_imm_s;
    logic [DATA_W-1:0]    imm_ext;
    logic [1:0]           pc_s;
    logic [1:0]           br_type;
    logic [4:0]           rs;
    logic [4:0]           rt;
    logic [4:0]           rd;
    logic [4:0]           shamt;
    logic                 illegal;
    logic [ILL_CNT_W-1:0] ill_cnt;

    modport master (
        output in_valid, inst, flush, out_ready,
        input  in_ready, out_valid, alu_op, write_reg, mem_write, mem_read, w_r_s,
               wr_data_s, rt_imm_s, imm_ext, pc_s, br_type, rs, rt, rd, shamt,
               illegal, ill_cnt
    );

    modport slave (
        input  in_valid, inst, flush, out_ready,
        output in_ready, out_valid, alu_op, write_reg, mem_write, mem_read, w_r_s,
               wr_data_s, rt_imm_s, imm_ext, pc_s, br_type, rs, rt, rd, shamt,
               illegal, ill_cnt
    );
endinterface

// File: rtl/inst_decode_stage.sv
// Registered MIPS decode stage with valid/ready handshake, load-use stall,
// flush and a saturating illegal-instruction counter.
module inst_decode_stage #(
    parameter int DATA_W    = 32,
    parameter int LOAD_LAT  = 1,
    parameter int ILL_CNT_W = 8
) (
    input logic clk,
    input logic rst_n,
    inst_decode_stage_if.slave bus
);
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_XORI = 6'b001110;
    localparam logic [5:0] OP_SLTIU= 6'b001011;
    localparam logic [5:0] OP_LUI  = 6'b001111;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;

    typedef struct packed {
        logic [3:0]        alu_op;
        logic              write_reg;
        logic              mem_write;
        logic              mem_read;
        logic [1:0]        w_r_s;
        logic [1:0]        wr_data_s;
        logic              rt_imm_s;
        logic [DATA_W-1:0] imm_ext;
        logic [1:0]        pc_s;
        logic [1:0]        br_type;
        logic [4:0]        rs;
        logic [4:0]        rt;
        logic [4:0]        rd;
        logic [4:0]        shamt;
        logic              illegal;
    } bundle_t;

    logic [5:0]           op, funct;
    logic [4:0]           rs_f, rt_f;
    logic [15:0]          imm;
    logic [DATA_W-1:0]    imm_z, imm_s, imm_lui;
    bundle_t              dec, q;
    logic                 q_valid;
    logic                 use_rs, use_rt;
    logic [1:0]           hz_cnt;
    logic [4:0]           ld_dst;
    logic                 stall, in_ready, xfer, new_load;
    logic [ILL_CNT_W-1:0] ill_cnt;

    assign op      = bus.inst[31:26];
    assign rs_f    = bus.inst[25:21];
    assign rt_f    = bus.inst[20:16];
    assign funct   = bus.inst[5:0];
    assign imm     = bus.inst[15:0];
    assign imm_z   = {{(DATA_W-16){1'b0}}, imm};
    assign imm_s   = {{(DATA_W-16){imm[15]}}, imm};
    assign imm_lui = DATA_W'({imm, 16'h0000});

    always_comb begin
        dec           = '0;
        dec.write_reg = 1'b1;
        dec.imm_ext   = imm_z;
        dec.rs        = rs_f;
        dec.rt        = rt_f;
        dec.rd        = bus.inst[15:11];
        dec.shamt     = bus.inst[10:6];
        use_rs        = 1'b1;
        use_rt        = 1'b0;
        case (op)
            OP_R: begin
                use_rt = 1'b1;
                case (funct)
                    6'b100000: dec.alu_op = 4'b0100;
                    6'b100010: dec.alu_op = 4'b0101;
                    6'b100100: dec.alu_op = 4'b0000;
                    6'b100101: dec.alu_op = 4'b0001;
                    6'b100110: dec.alu_op = 4'b0010;
                    6'b100111: dec.alu_op = 4'b0011;
                    6'b101011: dec.alu_op = 4'b0110;
                    6'b000100: dec.alu_op = 4'b0111;
                    6'b101010: dec.alu_op = 4'b1000;
                    6'b000010: dec.alu_op = 4'b1001;
                    6'b001000: begin dec.write_reg = 1'b0; dec.pc_s = 2'b01; end
                    default:   begin dec.illegal = 1'b1; dec.write_reg = 1'b0; end
                endcase
            end
            OP_ADDI, OP_ANDI, OP_XORI, OP_SLTIU, OP_LUI: begin
                dec.w_r_s    = 2'b01;
                dec.rt_imm_s = 1'b1;
                case (op)
                    OP_ADDI: begin dec.alu_op = 4'b0100; dec.imm_ext = imm_s; end
                    OP_ANDI:  dec.alu_op = 4'b0000;
                    OP_XORI:  dec.alu_op = 4'b0010;
                    OP_SLTIU: dec.alu_op = 4'b0110;
                    default: begin
                        dec.alu_op  = 4'b1010;
                        dec.imm_ext = imm_lui;
                        use_rs      = 1'b0;
                    end
                endcase
            end
            OP_LW: begin
                dec.w_r_s     = 2'b01;
                dec.wr_data_s = 2'b01;
                dec.mem_read  = 1'b1;
                dec.rt_imm_s  = 1'b1;
                dec.alu_op    = 4'b0100;
                dec.imm_ext   = imm_s;
            end
            OP_SW: begin
                dec.write_reg = 1'b0;
                dec.mem_write = 1'b1;
                dec.rt_imm_s  = 1'b1;
                dec.alu_op    = 4'b0100;
                dec.imm_ext   = imm_s;
                use_rt        = 1'b1;
            end
            OP_BEQ, OP_BNE: begin
                dec.write_reg = 1'b0;
                dec.alu_op    = 4'b0101;
                dec.pc_s      = 2'b10;
                dec.br_type   = (op == OP_BEQ) ? 2'b01 : 2'b10;
                dec.imm_ext   = imm_s;
                use_rt        = 1'b1;
            end
            OP_J: begin
                dec.write_reg = 1'b0;
                dec.pc_s      = 2'b11;
                use_rs        = 1'b0;
            end
            OP_JAL: begin
                dec.w_r_s     = 2'b10;
                dec.wr_data_s = 2'b10;
                dec.pc_s      = 2'b11;
                use_rs        = 1'b0;
            end
            default: begin
                dec.illegal   = 1'b1;
                dec.write_reg = 1'b0;
            end
        endcase
    end

    // $0 is never recorded as a load destination, so ld_dst==0 cannot match a real hazard.
    assign stall    = (hz_cnt != 2'd0) && bus.in_valid && (ld_dst != 5'd0) &&
                      ((use_rs && rs_f == ld_dst) || (use_rt && rt_f == ld_dst));
    assign in_ready = !bus.flush && !stall && (!q_valid || bus.out_ready);
    assign xfer     = bus.in_valid && in_ready;
    assign new_load = xfer && (op == OP_LW) && (rt_f != 5'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= '0;
            q_valid <= 1'b0;
        end else if (bus.flush) begin
            q_valid <= 1'b0;
        end else if (xfer) begin
            q       <= dec;
            q_valid <= 1'b1;
        end else if (bus.out_ready) begin
            q_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hz_cnt <= 2'd0;
            ld_dst <= 5'd0;
        end else if (bus.flush) begin
            hz_cnt <= 2'd0;
        end else if (new_load) begin
            hz_cnt <= 2'(LOAD_LAT);
            ld_dst <= rt_f;
        end else if (bus.out_ready && hz_cnt != 2'd0) begin
            hz_cnt <= hz_cnt - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ill_cnt <= '0;
        else if (xfer && dec.illegal && ill_cnt != {ILL_CNT_W{1'b1}})
            ill_cnt <= ill_cnt + 1'b1;
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = q_valid;
    assign bus.alu_op    = q.alu_op;
    assign bus.write_reg = q.write_reg;
    assign bus.mem_write = q.mem_write;
    assign bus.mem_read  = q.mem_read;
    assign bus.w_r_s     = q.w_r_s;
    assign bus.wr_data_s = q.wr_data_s;
    assign bus.rt_imm_s  = q.rt_imm_s;
    assign bus.imm_ext   = q.imm_ext;
    assign bus.pc_s      = q.pc_s;
    assign bus.br_type   = q.br_type;
    assign bus.rs        = q.rs;
    assign bus.rt        = q.rt;
    assign bus.rd        = q.rd;
    assign bus.shamt     = q.shamt;
    assign bus.illegal   = q.illegal;
    assign bus.ill_cnt   = ill_cnt;
endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed scenarios plus randomized traffic
// against a transaction-level reference model.
module tb_inst_decode_stage;
    localparam int DATA_W = 32, LOAD_LAT = 1, ILL_CNT_W = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    inst_decode_stage_if #(.DATA_W(DATA_W), .ILL_CNT_W(ILL_CNT_W)) bus ();
    inst_decode_stage #(.DATA_W(DATA_W), .LOAD_LAT(LOAD_LAT), .ILL_CNT_W(ILL_CNT_W))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [3:0]  alu_op;
        logic        write_reg, mem_write, mem_read, rt_imm_s, illegal;
        logic [1:0]  w_r_s, wr_data_s, pc_s, br_type;
        logic [31:0] imm_ext;
    } exp_t;

    int errors = 0, checks = 0;
    // reference model state
    logic        m_valid;
    logic [31:0] m_inst;
    exp_t        m_e;
    int          m_ill, m_hz;
    logic [4:0]  m_ld;
    logic        last_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Table-driven reference decode: what each instruction must produce.
    function automatic exp_t ref_dec(input logic [31:0] w);
        exp_t e;
        logic [5:0]  op = w[31:26], fn = w[5:0];
        logic [31:0] zx = {16'h0, w[15:0]};
        logic [31:0] sx = {{16{w[15]}}, w[15:0]};
        e = '{alu_op: 4'd0, write_reg: 1'b1, mem_write: 1'b0, mem_read: 1'b0, rt_imm_s: 1'b0,
              illegal: 1'b0, w_r_s: 2'd0, wr_data_s: 2'd0, pc_s: 2'd0, br_type: 2'd0, imm_ext: zx};
        if (op == 6'h00) begin
            case (fn)
                6'h20: e.alu_op = 4'd4;  6'h22: e.alu_op = 4'd5;
                6'h24: e.alu_op = 4'd0;  6'h25: e.alu_op = 4'd1;
                6'h26: e.alu_op = 4'd2;  6'h27: e.alu_op = 4'd3;
                6'h2B: e.alu_op = 4'd6;  6'h04: e.alu_op = 4'd7;
                6'h2A: e.alu_op = 4'd8;  6'h02: e.alu_op = 4'd9;
                6'h08: begin e.write_reg = 0; e.pc_s = 2'b01; end
                default: begin e.illegal = 1; e.write_reg = 0; end
            endcase
        end else begin
            case (op)
                6'h08: begin e.w_r_s = 1; e.rt_imm_s = 1; e.alu_op = 4'd4; e.imm_ext = sx; end
                6'h0C: begin e.w_r_s = 1; e.rt_imm_s = 1; e.alu_op = 4'd0; end
                6'h0E: begin e.w_r_s = 1; e.rt_imm_s = 1; e.alu_op = 4'd2; end
                6'h0B: begin e.w_r_s = 1; e.rt_imm_s = 1; e.alu_op = 4'd6; end
                6'h0F: begin e.w_r_s = 1; e.rt_imm_s = 1; e.alu_op = 4'd10; e.imm_ext = zx << 16; end
                6'h23: begin e.w_r_s = 1; e.wr_data_s = 1; e.mem_read = 1; e.rt_imm_s = 1;
                             e.alu_op = 4'd4; e.imm_ext = sx; end
                6'h2B: begin e.write_reg = 0; e.mem_write = 1; e.rt_imm_s = 1;
                             e.alu_op = 4'd4; e.imm_ext = sx; end
                6'h04, 6'h05: begin e.write_reg = 0; e.alu_op = 4'd5; e.pc_s = 2'b10;
                             e.br_type = (op == 6'h04) ? 2'b01 : 2'b10; e.imm_ext = sx; end
                6'h02: begin e.write_reg = 0; e.pc_s = 2'b11; end
                6'h03: begin e.w_r_s = 2; e.wr_data_s = 2; e.pc_s = 2'b11; end
                default: begin e.illegal = 1; e.write_reg = 0; end
            endcase
        end
        return e;
    endfunction

    function automatic bit reads_reg(input logic [31:0] w, input logic [4:0] r);
        logic [5:0] op = w[31:26];
        bit rs_used = !(op == 6'h02 || op == 6'h03 || op == 6'h0F);
        bit rt_used = (op == 6'h00 || op == 6'h2B || op == 6'h04 || op == 6'h05);
        if (r == 5'd0) return 0;
        return (rs_used && w[25:21] == r) || (rt_used && w[20:16] == r);
    endfunction

    function automatic bit model_rdy(input logic iv, input logic [31:0] w, input logic ord,
                                     input logic fl);
        bit stall = (m_hz != 0) && iv && reads_reg(w, m_ld);
        return !fl && !stall && (!m_valid || ord);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_ill = 0; m_hz = 0; m_ld = 0; m_inst = 0;
    endtask

    task automatic model_update(input logic iv, input logic [31:0] w, input logic ord,
                                input logic fl);
        bit acc = iv && model_rdy(iv, w, ord, fl);
        if (fl) begin
            m_valid = 0; m_hz = 0;
        end else begin
            if (acc) begin
                m_valid = 1; m_inst = w; m_e = ref_dec(w);
                if (m_e.illegal && m_ill < (1 << ILL_CNT_W) - 1) m_ill++;
            end else if (ord) m_valid = 0;
            if (acc && w[31:26] == 6'h23 && w[20:16] != 0) begin
                m_hz = LOAD_LAT; m_ld = w[20:16];
            end else if (ord && m_hz != 0) m_hz--;
        end
    endtask

    task automatic compare_outputs();
        chk("out_valid", bus.out_valid, m_valid);
        chk("ill_cnt", bus.ill_cnt, m_ill);
        if (m_valid) begin
            chk("alu_op", bus.alu_op, m_e.alu_op);
            chk("write_reg", bus.write_reg, m_e.write_reg);
            chk("mem_write", bus.mem_write, m_e.mem_write);
            chk("mem_read", bus.mem_read, m_e.mem_read);
            chk("w_r_s", bus.w_r_s, m_e.w_r_s);
            chk("wr_data_s", bus.wr_data_s, m_e.wr_data_s);
            chk("rt_imm_s", bus.rt_imm_s, m_e.rt_imm_s);
            chk("imm_ext", bus.imm_ext, m_e.imm_ext);
            chk("pc_s", bus.pc_s, m_e.pc_s);
            chk("br_type", bus.br_type, m_e.br_type);
            chk("illegal", bus.illegal, m_e.illegal);
            chk("fields", {bus.rs, bus.rt, bus.rd, bus.shamt}, m_inst[25:6]);
        end
    endtask

    // Called at a negedge: drive, check in_ready, advance one clock, check outputs.
    task automatic step(input logic iv, input logic [31:0] w, input logic ord, input logic fl);
        bus.in_valid = iv; bus.inst = w; bus.out_ready = ord; bus.flush = fl;
        #1;
        chk("in_ready", bus.in_ready, model_rdy(iv, w, ord, fl));
        last_rdy = bus.in_ready;
        @(posedge clk);
        model_update(iv, w, ord, fl);
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic do_reset();
        bus.in_valid = 0; bus.inst = 0; bus.out_ready = 0; bus.flush = 0;
        rst_n = 0; model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        #1 chk("in_ready_after_reset", bus.in_ready, 1'b1);
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0]  a = 5'($urandom_range(0, 7)), b = 5'($urandom_range(0, 7));
        logic [4:0]  c = 5'($urandom_range(0, 7)), s = 5'($urandom);
        logic [15:0] im = 16'($urandom);
        logic [5:0]  fns [12] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2B, 6'h04,
                                  6'h2A, 6'h02, 6'h08, 6'h3F};
        logic [5:0]  ops [13] = '{6'h08, 6'h0C, 6'h0E, 6'h0B, 6'h0F, 6'h23, 6'h23, 6'h2B,
                                  6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
        if ($urandom_range(0, 1) == 0)
            return {6'h00, a, b, c, s, fns[$urandom_range(0, 11)]};
        return {ops[$urandom_range(0, 12)], a, b, im};
    endfunction

    localparam logic [31:0] ADD3  = 32'h00221820;  // add $3,$1,$2
    localparam logic [31:0] ADDI4 = 32'h2004FFFF;  // addi $4,$0,-1
    localparam logic [31:0] LUI5  = 32'h3C051234;  // lui $5,0x1234
    localparam logic [31:0] LW6   = 32'h8C260000;  // lw $6,0($1)
    localparam logic [31:0] ADD76 = 32'h00C63820;  // add $7,$6,$6
    localparam logic [31:0] ADD70 = 32'h00003820;  // add $7,$0,$0
    localparam logic [31:0] BEQ   = 32'h10220003;
    localparam logic [31:0] BNE   = 32'h14220003;
    localparam logic [31:0] ILL   = 32'hFC000000;

    initial begin
        last_rdy = 0;
        do_reset();

        // Reset mid-stream with a valid bundle and ill_cnt=5.
        for (int i = 0; i < 5; i++) step(1, ILL, 1, 0);
        step(1, ADD3, 1, 0);
        chk("pre_reset_ill_cnt", bus.ill_cnt, 5);
        chk("pre_reset_valid", bus.out_valid, 1'b1);
        #2 rst_n = 0;
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_ill_cnt", bus.ill_cnt, 0);
        chk("rst_ctrl", {bus.alu_op, bus.write_reg, bus.rd, bus.pc_s}, 0);
        chk("rst_imm", bus.imm_ext, 0);
        model_reset();
        @(posedge clk); @(negedge clk);
        rst_n = 1;
        #1 chk("in_ready_after_midreset", bus.in_ready, 1'b1);

        // add then 3 cycles of backpressure
        step(1, ADD3, 1, 0);
        chk("add_valid", bus.out_valid, 1'b1);
        chk("add_alu", bus.alu_op, 4'b0100);
        chk("add_rd", bus.rd, 5'd3);
        chk("add_wr", {bus.write_reg, bus.w_r_s}, 3'b100);
        for (int i = 0; i < 3; i++) begin
            step(1, ADDI4, 0, 0);
            chk("hold_rdy", last_rdy, 1'b0);
            chk("hold_alu", bus.alu_op, 4'b0100);
        end
        step(0, 0, 1, 0);

        step(1, ADDI4, 1, 0);
        chk("addi_imm", bus.imm_ext, 32'hFFFFFFFF);
        step(1, LUI5, 1, 0);
        chk("lui_imm", bus.imm_ext, 32'h12340000);
        chk("lui_alu", bus.alu_op, 4'b1010);

        // load-use: one bubble
        step(1, LW6, 1, 0);
        chk("lw_mem_read", bus.mem_read, 1'b1);
        step(1, ADD76, 1, 0);
        chk("stall_rdy", last_rdy, 1'b0);
        chk("bubble", bus.out_valid, 1'b0);
        step(1, ADD76, 1, 0);
        chk("after_stall_rdy", last_rdy, 1'b1);
        chk("after_stall_rd", {bus.out_valid, bus.rd}, {1'b1, 5'd7});
        // consumer reads only $0: no stall
        step(1, LW6, 1, 0);
        step(1, ADD70, 1, 0);
        chk("no_stall_rdy", last_rdy, 1'b1);
        chk("no_stall_valid", bus.out_valid, 1'b1);

        // branches and flush
        step(1, BEQ, 1, 0);
        chk("beq_ctrl", {bus.pc_s, bus.br_type, bus.write_reg}, 5'b10010);
        step(1, BNE, 1, 0);
        chk("bne_br", bus.br_type, 2'b10);
        step(1, BEQ, 1, 0);
        step(1, ADD3, 0, 1);
        chk("flush_rdy", last_rdy, 1'b0);
        chk("flush_valid", bus.out_valid, 1'b0);
        step(1, LW6, 1, 0);
        step(1, ADD76, 0, 1);
        step(1, ADD76, 1, 0);
        chk("flush_clears_hz", last_rdy, 1'b1);

        // illegal counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) begin
            step(1, ILL, 1, 0);
            chk("ill_flag", {bus.illegal, bus.write_reg}, 2'b10);
        end
        chk("ill_sat", bus.ill_cnt, 8'd255);

        // randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++)
            step(($urandom_range(0, 3) != 0), rand_inst(), ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 19) == 0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/inst_decode_stage.md
Name: inst_decode_stage

Overview:
- Registered, handshaked MIPS decode stage. Successor to the combinational decoder.
- Accepts a fetched 32-bit instruction and emits a registered control/operand bundle to execute.
- Adds a parametrised immediate width, a 4-bit ALU op, extended ops (slt, srl, lui, lw mem_read), load-use hazard stalling, flush and an illegal-instruction counter.
- Branches are no longer resolved here: the stage emits br_type, and execute resolves it with ZF.

Parameters:
- DATA_W, 32: width of the extended immediate imm_ext (>=16).
- LOAD_LAT, 1: bubble cycles required between a load and a dependent consumer (1..3).
- ILL_CNT_W, 8: width of the saturating illegal-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  stage accepts the instruction this cycle.
- inst  in  32  instruction word.
- flush  in  1  kill the registered bundle and the hazard state.
- out_valid  out  1  bundle valid.
- out_ready  in  1  execute consumes the bundle.
- alu_op  out  4  ALU operation.
- write_reg  out  1  register write enable.
- mem_write  out  1  data-memory write enable.
- mem_read  out  1  load.
- w_r_s  out  2  write-register select: 00 rd, 01 rt, 10 r31.
- wr_data_s  out  2  write-data select: 00 ALU, 01 memory, 10 PC+4.
- rt_imm_s  out  1  ALU operand B: 0 rt, 1 imm.
- imm_ext  out  DATA_W  extended immediate.
- pc_s  out  2  next-PC select: 00 PC+4, 01 jr, 10 branch-conditional, 11 jump.
- br_type  out  2  branch type: 00 none, 01 beq, 10 bne.
- rs, rt, rd, shamt  out  5 each  instruction fields.
- illegal  out  1  undecodable instruction.
- ill_cnt  out  ILL_CNT_W  count of illegal instructions accepted.

Behaviour:
- Reset: all outputs are 0, including out_valid and ill_cnt. Hazard counter is 0. in_ready is 1 on the first cycle after reset deassertion.
- Transfer in: happens on in_valid && in_ready.
- in_ready = !flush && !stall && (!out_valid || out_ready).
- Bundle register:
  - A transfer in loads the decoded bundle and sets out_valid=1. Latency is 1 cycle.
  - Otherwise, if out_ready, out_valid goes to 0.
  - Otherwise the register holds, and all outputs stay stable while out_valid && !out_ready.
- Flush: out_valid goes to 0 next cycle, the hazard counter clears, and the input is not accepted that cycle. Flush takes priority over everything else.
- R-type decode (op=000000), by funct:
  - 100000 add: ALU 0100.
  - 100010 sub: 0101.
  - 100100 and: 0000.
  - 100101 or: 0001.
  - 100110 xor: 0010.
  - 100111 nor: 0011.
  - 101011 sltu: 0110.
  - 000100 sllv: 0111.
  - 101010 slt: 1000.
  - 000010 srl: 1001, operand is shamt.
  - 001000 jr: write_reg=0, pc_s=01.
  - Any other funct: illegal=1, write_reg=0.
- I/J-type decode (imm_ext is sign-extended where noted, zero-extended otherwise):
  - addi 001000: w_r_s=01, sign-ext, rt_imm_s=1, ALU 0100.
  - andi 001100: 0000.
  - xori 001110: 0010.
  - sltiu 001011: 0110.
  - lui 001111: ALU 1010, imm_ext = imm<<16, zero-filled above bit 31.
  - lw 100011: w_r_s=01, sign-ext, wr_data_s=01, mem_read=1, ALU 0100.
  - sw 101011: sign-ext, write_reg=0, mem_write=1.
  - beq 000100: ALU 0101, pc_s=10, br_type=01, write_reg=0, imm_ext sign-extended.
  - bne 000101: same as beq with br_type=10.
  - j 000010: write_reg=0, pc_s=11.
  - jal 000011: w_r_s=10, wr_data_s=10, pc_s=11.
  - Any other opcode: illegal=1, write_reg=0, mem_write=0.
- Default fields for any bundle: write_reg=1 and all other controls 0, except as listed above.
- Sign extension replicates imm[15] up to DATA_W-1.
- Illegal counter: increments on each accepted illegal instruction and saturates at all-ones.
- Load-use hazard:
  - When a lw with rt!=0 is accepted, the stage records ld_dst=rt and sets hz_cnt=LOAD_LAT.
  - hz_cnt decrements on each cycle out_ready=1 and the stage is not accepting a new load.
  - stall = hz_cnt!=0 && in_valid && incoming inst reads ld_dst.
  - An instruction reads rs for all except j, jal and lui. It reads rt for R-type, sw, beq and bne.
  - During a stall, no transfer in occurs, so a bubble appears at the output.
  - Register 0 never causes a stall.
- Back-to-back loads: the newer load overwrites ld_dst and hz_cnt.

Test Plan:
- Reset mid-stream: assert rst_n=0 with out_valid=1 and ill_cnt=5 -> all outputs 0 immediately. After release, in_ready=1.
- add $3,$1,$2 (0x00221820) with out_ready=1 -> next cycle out_valid=1, alu_op=0100, rd=3, write_reg=1, w_r_s=00. Hold out_ready=0 for 3 cycles -> bundle stable and in_ready=0.
- addi $4,$0,-1 (0x2004FFFF), DATA_W=32 -> imm_ext=0xFFFFFFFF. lui $5,0x1234 -> imm_ext=0x12340000, alu_op=1010.
- lw $6,0($1) followed by add $7,$6,$6, LOAD_LAT=1, out_ready=1 -> the add is held one cycle, one bubble cycle has out_valid=0, then the add issues. Repeat with the consumer reading $0 -> no stall.
- beq taken/untaken patterns -> pc_s=10, br_type=01, write_reg=0. Flush asserted while the beq bundle is valid -> out_valid=0 next cycle and hz_cnt cleared.
- 300 accepted illegal words (op=111111), ILL_CNT_W=8 -> illegal=1 on each, write_reg=0, ill_cnt saturates at 255.
